// File: rtl/prog_counter_if.sv
// Fetch-stage handshake bundle between the test harness and prog_counter.
// The harness drives Start/Stall/Branch/Target/Halt. The sequencer returns
// the PC, its Run/Done state flags and the executed-instruction count.
interface prog_counter_if #(
  parameter int unsigned D  = 12,
  parameter int unsigned CW = 16
);
  logic          Start;
  logic          Stall;
  logic          Branch;
  logic [D-1:0]  Target;
  logic          Halt;
  logic [D-1:0]  Prog_ctr;
  logic          Run;
  logic          Done;
  logic [CW-1:0] Instr_cnt;

  modport master (
    output Start, Stall, Branch, Target, Halt,
    input  Prog_ctr, Run, Done, Instr_cnt
  );

  modport slave (
    input  Start, Stall, Branch, Target, Halt,
    output Prog_ctr, Run, Done, Instr_cnt
  );
endinterface

// File: rtl/prog_counter.sv
// Program-counter sequencer for the fetch stage.
// It holds the instruction address and advances it by one for each executed
// cycle. When a branch is taken it instead adds the signed relative offset.
// It also runs the IDLE/RUN/DONE handshake with the harness and keeps a
// saturating count of executed instructions.
module prog_counter #(
  parameter int unsigned     D          = 12,
  parameter logic [D-1:0]    START_ADDR = '0,
  parameter int unsigned     CW         = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  prog_counter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  logic [D-1:0]  pc;
  logic [CW-1:0] cnt;
  logic          run_q;
  logic          done_q;

  logic [D-1:0]  pc_step;
  logic [D-1:0]  pc_next;
  logic [CW-1:0] cnt_next;

  // Next PC and next count for an executed (non-stalled) RUN cycle.
  // Target is already two's complement, so a plain D-bit add with the
  // carry dropped gives the wrapped relative branch.
  always_comb begin
    pc_step  = bus.Branch ? bus.Target : D'(1);
    pc_next  = pc + pc_step;
    cnt_next = (cnt == '1) ? cnt : cnt + CW'(1);
  end

  // Sequencer FSM. Run and Done are registered copies of the state,
  // so there is no combinational path from any input to the flags.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= S_IDLE;
      pc     <= START_ADDR;
      cnt    <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.Start) begin
            state  <= S_RUN;
            pc     <= START_ADDR;
            cnt    <= '0;
            run_q  <= 1'b1;
            done_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (!bus.Stall) begin
            cnt <= cnt_next;
            if (bus.Halt) begin
              state  <= S_DONE;
              run_q  <= 1'b0;
              done_q <= 1'b1;
            end else begin
              pc <= pc_next;
            end
          end
        end
        default: begin
          state  <= S_IDLE;
          pc     <= START_ADDR;
          cnt    <= '0;
          run_q  <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Prog_ctr  = pc;
  assign bus.Instr_cnt = cnt;
  assign bus.Run       = run_q;
  assign bus.Done      = done_q;

endmodule
